// File: rtl/jtag_cmd_sysclk_bridge_pkg.sv
// -----------------------------------------------------------------------------
// jtag_bridge_pkg
// Shared constants and types for the JTAG command system-clock bridge:
//   - default IR / DR widths and the action-bit position
//   - channel-index type (one command channel per IR value)
//   - statistics counter width and a saturating increment helper
// -----------------------------------------------------------------------------
package jtag_bridge_pkg;

  localparam int IR_W_DEF    = 2;
  localparam int DR_W_DEF    = 38;
  localparam int ACT_BIT_DEF = 34;
  localparam int STAT_W      = 16;

  typedef logic [IR_W_DEF-1:0] ch_idx_t;
  typedef logic [STAT_W-1:0]   stat_cnt_t;

  // Counters stick at all-ones rather than wrapping back to zero.
  function automatic stat_cnt_t sat_inc(stat_cnt_t v);
    return (v == '1) ? v : v + stat_cnt_t'(1);
  endfunction

endpackage

// File: rtl/jtag_cmd_sysclk_bridge_if.sv
// -----------------------------------------------------------------------------
// jtag_cmd_sysclk_bridge_if
// Bundles the bridge's TCK-side event inputs, the consumer handshake and the
// status outputs.
//   slave  : the bridge (consumes toggles/sr/ready, drives jdo/cmd_*/status)
//   master : the environment (TCK shifter + debug consumers)
// Optional: JTAG_BRIDGE_STATS_EN adds acc_cnt / drop_cnt.
// -----------------------------------------------------------------------------
interface jtag_cmd_sysclk_bridge_if
  import jtag_bridge_pkg::*;
#(
  parameter int IR_W    = IR_W_DEF,
  parameter int DR_W    = DR_W_DEF,
  parameter int NUM_CMD = 4
) ();

  logic                uir_tog;
  logic                e1dr_tog;
  logic [IR_W-1:0]     ir_in;
  logic [DR_W-1:0]     sr;
  logic [NUM_CMD-1:0]  cmd_ready;
  logic                ovf_clr;
  logic [DR_W-1:0]     jdo;
  logic [NUM_CMD-1:0]  cmd_valid;
  logic                cmd_act;
  logic                cmd_busy;
  logic                ovf_sticky;
  logic                bad_ir;
`ifdef JTAG_BRIDGE_STATS_EN
  stat_cnt_t           acc_cnt;
  stat_cnt_t           drop_cnt;

  modport slave (
    input  uir_tog, e1dr_tog, ir_in, sr, cmd_ready, ovf_clr,
    output jdo, cmd_valid, cmd_act, cmd_busy, ovf_sticky, bad_ir, acc_cnt, drop_cnt
  );
  modport master (
    output uir_tog, e1dr_tog, ir_in, sr, cmd_ready, ovf_clr,
    input  jdo, cmd_valid, cmd_act, cmd_busy, ovf_sticky, bad_ir, acc_cnt, drop_cnt
  );
`else
  modport slave (
    input  uir_tog, e1dr_tog, ir_in, sr, cmd_ready, ovf_clr,
    output jdo, cmd_valid, cmd_act, cmd_busy, ovf_sticky, bad_ir
  );
  modport master (
    output uir_tog, e1dr_tog, ir_in, sr, cmd_ready, ovf_clr,
    input  jdo, cmd_valid, cmd_act, cmd_busy, ovf_sticky, bad_ir
  );
`endif

endinterface

// File: rtl/jtag_cmd_sysclk_bridge_toggle_sync_edge.sv
// -----------------------------------------------------------------------------
// toggle_sync_edge
// Brings a TCK-domain toggle into clk through a SYNC_STAGES flop chain and
// turns each level change into a one-cycle event.
//   clk, reset : system clock, synchronous active-high reset
//   tog_i      : asynchronous toggle input
//   settle_i   : post-reset guard; events are suppressed while high
//   edge_o     : one-cycle event pulse (last stage XOR prev)
// -----------------------------------------------------------------------------
module toggle_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic tog_i,
  input  logic settle_i,
  output logic edge_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // NOTE: sequential state uses non-blocking assignments only, and reset is
  // sampled on the clock edge (synchronous), never in the sensitivity list.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tog_i};
      // prev always follows the last stage, so during the settle window it
      // quietly absorbs whatever level the toggle was left at across reset.
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_o = !settle_i && (sync_q[SYNC_STAGES-1] ^ prev_q);

endmodule

// File: rtl/jtag_cmd_sysclk_bridge.sv
// -----------------------------------------------------------------------------
// jtag_cmd_sysclk_bridge
// System-clock half of the CPU JTAG debug slave. Synchronises update-IR and
// exit1-DR toggle events, captures IR and DR, and presents a one-hot
// per-channel command with valid/ready handshake, overflow and bad-IR flags.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : jtag_cmd_sysclk_bridge_if.slave (toggles, ir_in, sr,
//                cmd_ready, ovf_clr in; jdo, cmd_valid, cmd_act, cmd_busy,
//                ovf_sticky, bad_ir out)
// Optional: define JTAG_BRIDGE_STATS_EN for acc_cnt / drop_cnt counters.
// All outputs come straight from flops (cmd_busy is an OR of flops).
// -----------------------------------------------------------------------------
module jtag_cmd_sysclk_bridge
  import jtag_bridge_pkg::*;
#(
  parameter int IR_W        = IR_W_DEF,
  parameter int DR_W        = DR_W_DEF,
  parameter int NUM_CMD     = 4,
  parameter int ACT_BIT     = ACT_BIT_DEF,
  parameter int SYNC_STAGES = 2
) (
  input logic                     clk,
  input logic                     reset,
  jtag_cmd_sysclk_bridge_if.slave bus
);

  localparam int              SETTLE_N  = SYNC_STAGES + 1;
  localparam int              CNT_W     = $clog2(SETTLE_N + 1);
  localparam logic [IR_W:0]   NUM_CMD_L = (IR_W + 1)'(NUM_CMD);

  logic [CNT_W-1:0]   settle_q, settle_d;
  logic               settle;
  logic               uir_edge, e1dr_edge;
  logic [IR_W-1:0]    ir_q, ir_d;
  logic [DR_W-1:0]    jdo_q, jdo_d;
  logic [NUM_CMD-1:0] cmd_valid_q, cmd_valid_d;
  logic               cmd_act_q, cmd_act_d;
  logic               ovf_q, ovf_d;
  logic               bad_ir_q, bad_ir_d;
  logic               ch_ok, accept, busy, bad_ev, overflow, take;

  // Shared guard: high for SYNC_STAGES+1 cycles after reset deasserts.
  assign settle   = (settle_q != CNT_W'(SETTLE_N));
  assign settle_d = settle ? settle_q + CNT_W'(1) : settle_q;

  toggle_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_uir_sync (
    .clk, .reset, .tog_i(bus.uir_tog), .settle_i(settle), .edge_o(uir_edge)
  );

  toggle_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_e1dr_sync (
    .clk, .reset, .tog_i(bus.e1dr_tog), .settle_i(settle), .edge_o(e1dr_edge)
  );

  // cmd_valid is one-hot, so this is "pending channel's valid and ready".
  assign accept   = |(cmd_valid_q & bus.cmd_ready);
  // A same-cycle acceptance frees the slot for the incoming command.
  assign busy     = (|cmd_valid_q) && !accept;
  assign ch_ok    = ({1'b0, ir_q} < NUM_CMD_L);
  assign bad_ev   = e1dr_edge && !ch_ok;
  assign overflow = e1dr_edge && ch_ok && busy;
  assign take     = e1dr_edge && ch_ok && !busy;

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    ir_d        = ir_q;
    jdo_d       = jdo_q;
    cmd_valid_d = cmd_valid_q;
    cmd_act_d   = cmd_act_q;
    ovf_d       = ovf_q;
    bad_ir_d    = bad_ev;

    if (uir_edge) ir_d = bus.ir_in;
    if (accept)   cmd_valid_d = '0;
    if (bus.ovf_clr) ovf_d = 1'b0;
    // Applied after the clear so a simultaneous overflow keeps the flag set.
    if (overflow) ovf_d = 1'b1;
    if (take) begin
      jdo_d       = bus.sr;
      cmd_valid_d = NUM_CMD'(1) << ir_q;
      cmd_act_d   = bus.sr[ACT_BIT];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      settle_q    <= '0;
      ir_q        <= '0;
      jdo_q       <= '0;
      cmd_valid_q <= '0;
      cmd_act_q   <= 1'b0;
      ovf_q       <= 1'b0;
      bad_ir_q    <= 1'b0;
    end else begin
      settle_q    <= settle_d;
      ir_q        <= ir_d;
      jdo_q       <= jdo_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_act_q   <= cmd_act_d;
      ovf_q       <= ovf_d;
      bad_ir_q    <= bad_ir_d;
    end
  end

  assign bus.jdo        = jdo_q;
  assign bus.cmd_valid  = cmd_valid_q;
  assign bus.cmd_act    = cmd_act_q;
  assign bus.cmd_busy   = |cmd_valid_q;
  assign bus.ovf_sticky = ovf_q;
  assign bus.bad_ir     = bad_ir_q;

`ifdef JTAG_BRIDGE_STATS_EN
  stat_cnt_t acc_q, acc_d, drop_q, drop_d;

  // Clear first, then count, so an event in the clearing cycle is kept.
  always_comb begin
    acc_d  = bus.ovf_clr ? '0 : acc_q;
    drop_d = bus.ovf_clr ? '0 : drop_q;
    if (accept)              acc_d  = sat_inc(acc_d);
    if (overflow || bad_ev)  drop_d = sat_inc(drop_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q  <= '0;
      drop_q <= '0;
    end else begin
      acc_q  <= acc_d;
      drop_q <= drop_d;
    end
  end

  assign bus.acc_cnt  = acc_q;
  assign bus.drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_jtag_cmd_sysclk_bridge.sv
// -----------------------------------------------------------------------------
// tb_jtag_cmd_sysclk_bridge
// Directed scenarios plus a randomized run against an event-level model of
// the bridge (pending channel, captured data, overflow flag). Built with
// NUM_CMD = 3 so IR value 3 is an illegal channel.
// -----------------------------------------------------------------------------
module tb_jtag_cmd_sysclk_bridge;
  import jtag_bridge_pkg::*;

  localparam int IR_W    = 2;
  localparam int DR_W    = 38;
  localparam int NUM_CMD = 3;
  localparam int ACT_BIT = 34;
  localparam int S       = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Event-level reference model.
  int              m_pend;
  logic [DR_W-1:0] m_jdo;
  logic            m_act;
  logic            m_ovf;
  ch_idx_t         m_ir;
  int              m_acc;
  int              m_drop;

  always #5 clk = ~clk;

  jtag_cmd_sysclk_bridge_if #(.IR_W(IR_W), .DR_W(DR_W), .NUM_CMD(NUM_CMD)) bus ();

  jtag_cmd_sysclk_bridge #(
    .IR_W(IR_W), .DR_W(DR_W), .NUM_CMD(NUM_CMD), .ACT_BIT(ACT_BIT), .SYNC_STAGES(S)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- model ----------------
  task automatic model_reset();
    m_pend = -1; m_jdo = '0; m_act = 1'b0; m_ovf = 1'b0; m_ir = '0;
    m_acc = 0; m_drop = 0;
  endtask

  function automatic logic [NUM_CMD-1:0] exp_valid();
    logic [NUM_CMD-1:0] v;
    for (int i = 0; i < NUM_CMD; i++) v[i] = (i == m_pend);
    return v;
  endfunction

  task automatic model_accept(input logic [NUM_CMD-1:0] rdy);
    if (m_pend >= 0 && rdy[m_pend]) begin
      m_pend = -1;
      m_acc++;
    end
  endtask

  task automatic model_e1dr(input logic [DR_W-1:0] srv, input logic [NUM_CMD-1:0] rdy,
                            input logic clr, output logic bad);
    bad = 1'b0;
    if (clr) begin m_ovf = 1'b0; m_acc = 0; m_drop = 0; end
    model_accept(rdy);
    if (int'(m_ir) >= NUM_CMD) begin
      bad = 1'b1; m_drop++;
    end else if (m_pend >= 0) begin
      m_ovf = 1'b1; m_drop++;
    end else begin
      m_pend = int'(m_ir); m_jdo = srv; m_act = srv[ACT_BIT];
    end
  endtask

  // ---------------- stimulus ----------------
  task automatic send_uir(input ch_idx_t ir);
    @(negedge clk);
    bus.ir_in   = ir;
    bus.uir_tog = ~bus.uir_tog;
    repeat (S + 2) @(posedge clk);
    m_ir = ir;
  endtask

  // Toggles e1dr; cmd_ready/ovf_clr are applied only in the cycle the event
  // is decoded. Returns cmd_valid one cycle before the expected update.
  task automatic send_e1dr(input logic [DR_W-1:0] srv, input logic [NUM_CMD-1:0] rdy,
                           input logic clr, output logic [NUM_CMD-1:0] pre, output logic bad);
    @(negedge clk);
    bus.sr        = srv;
    bus.cmd_ready = '0;
    bus.e1dr_tog  = ~bus.e1dr_tog;
    repeat (S) @(posedge clk);
    @(negedge clk);
    pre           = bus.cmd_valid;
    bus.cmd_ready = rdy;
    bus.ovf_clr   = clr;
    @(posedge clk);
    model_e1dr(srv, rdy, clr, bad);
    @(negedge clk);
    bus.cmd_ready = '0;
    bus.ovf_clr   = 1'b0;
  endtask

  task automatic do_accept(input logic [NUM_CMD-1:0] rdy);
    @(negedge clk);
    bus.cmd_ready = rdy;
    @(posedge clk);
    model_accept(rdy);
    @(negedge clk);
    bus.cmd_ready = '0;
  endtask

  task automatic do_clr();
    @(negedge clk);
    bus.ovf_clr = 1'b1;
    @(posedge clk);
    m_ovf = 1'b0; m_acc = 0; m_drop = 0;
    @(negedge clk);
    bus.ovf_clr = 1'b0;
  endtask

  function automatic logic [DR_W-1:0] rand_sr();
    return DR_W'({$urandom(), $urandom()});
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    logic seen;
    bus.uir_tog = 1'b1; bus.e1dr_tog = 1'b1; bus.ir_in = '0; bus.sr = '0;
    bus.cmd_ready = '0; bus.ovf_clr = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.cmd_valid !== '0 || bus.jdo !== '0 || bus.cmd_act !== 1'b0 ||
        bus.cmd_busy !== 1'b0 || bus.ovf_sticky !== 1'b0 || bus.bad_ir !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b jdo=%h act=%b busy=%b ovf=%b bad=%b, all required 0",
               bus.cmd_valid, bus.jdo, bus.cmd_act, bus.cmd_busy, bus.ovf_sticky, bus.bad_ir);
    end
    reset = 1'b0;
    model_reset();
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.cmd_valid !== '0 || bus.bad_ir !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL settle_guard: spurious event after reset with toggles held at 1");
    end
  endtask

  task automatic test_cmd();
    logic [NUM_CMD-1:0] pre;
    logic bad;
    send_uir(2'd1);
    send_e1dr(38'h04_0000_00AB, '0, 1'b0, pre, bad);
    n_checks++;
    if (pre !== 3'b000) begin
      n_fail++; $display("FAIL latency_early: valid=%b one cycle early, required 000", pre);
    end
    n_checks++;
    if (bus.cmd_valid !== 3'b010) begin
      n_fail++; $display("FAIL cmd_valid: got %b required 010", bus.cmd_valid);
    end
    n_checks++;
    if (bus.jdo !== 38'h04_0000_00AB || bus.cmd_act !== 1'b1 || bus.cmd_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL cmd_capture: jdo=%h act=%b busy=%b required 04000000ab/1/1",
               bus.jdo, bus.cmd_act, bus.cmd_busy);
    end
    do_accept(3'b101);
    repeat (4) @(negedge clk);
    n_checks++;
    if (bus.cmd_valid !== 3'b010 || bus.jdo !== 38'h04_0000_00AB) begin
      n_fail++;
      $display("FAIL hold_no_ready: valid=%b jdo=%h required 010/04000000ab",
               bus.cmd_valid, bus.jdo);
    end
    do_accept(3'b010);
    n_checks++;
    if (bus.cmd_valid !== 3'b000 || bus.cmd_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL accept_clear: valid=%b busy=%b required 000/0", bus.cmd_valid, bus.cmd_busy);
    end
  endtask

  task automatic test_overflow();
    logic [NUM_CMD-1:0] pre;
    logic bad;
    send_e1dr(38'h04_0000_00AB, '0, 1'b0, pre, bad);
    send_e1dr(38'h00_0000_0055, '0, 1'b0, pre, bad);
    n_checks++;
    if (bus.jdo !== 38'h04_0000_00AB || bus.cmd_valid !== 3'b010 || bus.ovf_sticky !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow: jdo=%h valid=%b ovf=%b required 04000000ab/010/1",
               bus.jdo, bus.cmd_valid, bus.ovf_sticky);
    end
`ifdef JTAG_BRIDGE_STATS_EN
    n_checks++;
    if (bus.drop_cnt !== 16'd1) begin
      n_fail++; $display("FAIL drop_cnt: got %0d required 1", bus.drop_cnt);
    end
`endif
    do_clr();
    n_checks++;
    if (bus.ovf_sticky !== 1'b0) begin
      n_fail++; $display("FAIL ovf_clr: got %b required 0", bus.ovf_sticky);
    end
    // Clear coinciding with a new drop: the set must win.
    send_e1dr(38'h00_0000_0066, '0, 1'b1, pre, bad);
    n_checks++;
    if (bus.ovf_sticky !== 1'b1 || bus.jdo !== 38'h04_0000_00AB) begin
      n_fail++;
      $display("FAIL ovf_set_wins: ovf=%b jdo=%h required 1/04000000ab", bus.ovf_sticky, bus.jdo);
    end
    do_clr();
  endtask

  task automatic test_back_to_back();
    logic [NUM_CMD-1:0] pre;
    logic bad;
    send_uir(2'd0);  // IR updates even while channel 1 is pending
    send_e1dr(38'h00_0000_0011, 3'b010, 1'b0, pre, bad);
    n_checks++;
    if (bus.cmd_valid !== 3'b001 || bus.cmd_act !== 1'b0 || bus.jdo !== 38'h00_0000_0011 ||
        bus.ovf_sticky !== 1'b0) begin
      n_fail++;
      $display("FAIL accept_and_new: valid=%b act=%b jdo=%h ovf=%b required 001/0/0000000011/0",
               bus.cmd_valid, bus.cmd_act, bus.jdo, bus.ovf_sticky);
    end
    send_e1dr(38'h04_0000_0022, 3'b001, 1'b0, pre, bad);
    n_checks++;
    if (bus.cmd_valid !== 3'b001 || bus.cmd_act !== 1'b1 || bus.jdo !== 38'h04_0000_0022 ||
        bus.ovf_sticky !== 1'b0) begin
      n_fail++;
      $display("FAIL same_channel_rearm: valid=%b act=%b jdo=%h ovf=%b required 001/1/0400000022/0",
               bus.cmd_valid, bus.cmd_act, bus.jdo, bus.ovf_sticky);
    end
    do_accept(3'b001);
  endtask

  task automatic test_bad_ir();
    logic [NUM_CMD-1:0] pre;
    logic bad;
    send_uir(2'd3);
    send_e1dr(rand_sr(), '0, 1'b0, pre, bad);
    n_checks++;
    if (bus.bad_ir !== 1'b1 || bus.cmd_valid !== 3'b000 || bus.ovf_sticky !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_ir_pulse: bad=%b valid=%b ovf=%b required 1/000/0",
               bus.bad_ir, bus.cmd_valid, bus.ovf_sticky);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.bad_ir !== 1'b0) begin
      n_fail++; $display("FAIL bad_ir_single: got %b required 0", bus.bad_ir);
    end
  endtask

  task automatic test_reset_mid();
    logic [NUM_CMD-1:0] pre;
    logic bad;
    logic [DR_W-1:0] v;
    send_uir(2'd2);
    send_e1dr(rand_sr(), '0, 1'b0, pre, bad);
    n_checks++;
    if (bus.cmd_valid !== 3'b100) begin
      n_fail++; $display("FAIL pend_ch2: got %b required 100", bus.cmd_valid);
    end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.cmd_valid !== '0 || bus.jdo !== '0 || bus.cmd_act !== 1'b0 ||
        bus.cmd_busy !== 1'b0 || bus.ovf_sticky !== 1'b0 || bus.bad_ir !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: valid=%b jdo=%h act=%b busy=%b ovf=%b bad=%b, all required 0",
               bus.cmd_valid, bus.jdo, bus.cmd_act, bus.cmd_busy, bus.ovf_sticky, bus.bad_ir);
    end
    @(negedge clk); reset = 1'b0;
    model_reset();
    repeat (S + 3) @(posedge clk);
    v = rand_sr();
    send_uir(2'd1);
    send_e1dr(v, '0, 1'b0, pre, bad);
    n_checks++;
    if (bus.cmd_valid !== 3'b010 || bus.jdo !== v || bus.cmd_act !== v[ACT_BIT]) begin
      n_fail++;
      $display("FAIL after_reset_decode: valid=%b jdo=%h act=%b required 010/%h/%b",
               bus.cmd_valid, bus.jdo, bus.cmd_act, v, v[ACT_BIT]);
    end
    do_accept(3'b111);
  endtask

  task automatic test_random();
    logic [NUM_CMD-1:0] pre;
    logic bad;
    for (int it = 0; it < 200; it++) begin
      bad = 1'b0;
      case ($urandom_range(0, 3))
        0:       send_uir(ch_idx_t'($urandom_range(0, 3)));
        1:       send_e1dr(rand_sr(), NUM_CMD'($urandom_range(0, 7)),
                           ($urandom_range(0, 7) == 0), pre, bad);
        2:       do_accept(NUM_CMD'($urandom_range(0, 7)));
        default: do_clr();
      endcase
      n_checks++;
      if (bus.cmd_valid !== exp_valid() || bus.cmd_busy !== (m_pend >= 0) ||
          bus.jdo !== m_jdo || bus.cmd_act !== m_act || bus.ovf_sticky !== m_ovf ||
          bus.bad_ir !== bad) begin
        n_fail++;
        $display("FAIL random[%0d]: valid=%b busy=%b jdo=%h act=%b ovf=%b bad=%b required %b/%b/%h/%b/%b/%b",
                 it, bus.cmd_valid, bus.cmd_busy, bus.jdo, bus.cmd_act, bus.ovf_sticky, bus.bad_ir,
                 exp_valid(), (m_pend >= 0), m_jdo, m_act, m_ovf, bad);
      end
`ifdef JTAG_BRIDGE_STATS_EN
      n_checks++;
      if (int'(bus.acc_cnt) != m_acc || int'(bus.drop_cnt) != m_drop) begin
        n_fail++;
        $display("FAIL random_stats[%0d]: acc=%0d drop=%0d required %0d/%0d",
                 it, bus.acc_cnt, bus.drop_cnt, m_acc, m_drop);
      end
`endif
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_cmd();
    test_overflow();
    test_back_to_back();
    test_bad_ir();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jtag_cmd_sysclk_bridge.md
Name: jtag_cmd_sysclk_bridge

Overview:
Parametrised system-clock half of the CPU JTAG debug slave. It takes toggle-encoded update-IR and exit1-DR events from the TCK-domain shifter and synchronises them into clk. It captures the scanned data register and IR, and presents decoded per-channel commands to the debug consumers with a valid/ready handshake. It generalises the fixed 2-bit-IR / 38-bit-DR / pulse-only decode to N channels, with backpressure, overflow detection and a post-reset settle guard.

Parameters:
IR_W, 2, JTAG IR width; channel index = captured IR
DR_W, 38, data register width
NUM_CMD, 4, number of command channels; legal range 1 to 2**IR_W
ACT_BIT, 34, DR bit selecting action (1) versus no-action (0); must be below DR_W
SYNC_STAGES, 2, synchroniser depth; minimum 2

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
uir_tog  in  1  TCK-domain toggle; each transition is one update-IR event
e1dr_tog  in  1  TCK-domain toggle; each transition is one exit1-DR event
ir_in  in  IR_W  TCK-domain IR; stable from the uir_tog transition until the next one
sr  in  DR_W  TCK-domain shift register; stable for at least SYNC_STAGES+2 clk cycles after an e1dr_tog transition
cmd_ready  in  NUM_CMD  per-channel consumer ready
ovf_clr  in  1  clears ovf_sticky
jdo  out  DR_W  captured data register
cmd_valid  out  NUM_CMD  one-hot pending command
cmd_act  out  1  jdo[ACT_BIT] of the pending command
cmd_busy  out  1  OR of cmd_valid
ovf_sticky  out  1  a command was dropped
bad_ir  out  1  one-cycle pulse: exit1-DR event arrived with captured IR >= NUM_CMD

Behaviour:
- Reset values: all synchroniser and edge flops, jdo, ir_q, cmd_valid, cmd_act, ovf_sticky, bad_ir and the settle counter are 0.
- Synchronisation and edge detection: each toggle passes through a SYNC_STAGES flop chain plus a prev flop. edge = last_stage XOR prev.
- Settle guard: a counter runs for SYNC_STAGES+1 cycles after reset deasserts. While it runs, edges are ignored and prev tracks last_stage. A toggle left at 1 across reset therefore produces no spurious event.
- uir edge: ir_q <= ir_in. This happens regardless of cmd_busy.
- e1dr edge, with ch = ir_q:
  - ch >= NUM_CMD: bad_ir = 1 in the next cycle; no other state changes.
  - Block free: jdo <= sr, cmd_valid[ch] <= 1, cmd_act <= sr[ACT_BIT].
  - Block busy (see below): the event is dropped, jdo is held, and ovf_sticky <= 1.
- Busy rule: busy = cmd_busy AND NOT (the pending channel's valid and ready are both high this cycle). An acceptance in the same cycle as an edge frees the block, so the new command is taken and cmd_valid moves to the new channel, or stays high if it is the same channel.
- Latency: an input toggle transition leads to cmd_valid/jdo registered SYNC_STAGES+1 clk cycles later, measured from the first clk edge that samples the new level.
- Handshake:
  - cmd_valid[i] holds until a cycle in which cmd_valid[i] and cmd_ready[i] are both high; it clears in the next cycle unless re-armed.
  - jdo and cmd_act are stable while cmd_busy is high.
  - cmd_ready on non-pending channels is ignored.
- ovf_clr and an overflow in the same cycle: the set wins, so ovf_sticky stays 1.
- Reset mid-operation: a pending command is discarded, and events in flight in the synchroniser are lost.
- No combinational path from any input to any output.

Optional Feature:
JTAG_BRIDGE_STATS_EN
- Defined: adds outputs acc_cnt[15:0] and drop_cnt[15:0], both reset to 0.
  - acc_cnt increments on each valid/ready acceptance.
  - drop_cnt increments on each overflow drop and each bad_ir event.
  - Both counters saturate at 16'hFFFF and are cleared by ovf_clr.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package jtag_bridge_pkg:
  - default IR_W, DR_W and ACT_BIT constants;
  - a channel-index typedef;
  - the stats counter width constant (16).
- Sub-module toggle_sync_edge (parameter SYNC_STAGES; ports clk, reset, tog, settle, edge):
  - contains the chain, prev flop and guard masking;
  - instantiated twice (uir, e1dr).
- The settle counter lives in the top level and is shared by both instances.

Test Plan:
- Reset with uir_tog = e1dr_tog = 1 held, then release -> no cmd_valid and no bad_ir for 20 cycles.
- Toggle uir with ir_in = 2'd1, then toggle e1dr with sr = 38'h04_0000_00AB (bit 34 set), cmd_ready = 0 -> cmd_valid = 4'b0010 at SYNC_STAGES+1 cycles, jdo = 38'h04_0000_00AB, cmd_act = 1, held until ready; cmd_ready[1] = 1 clears cmd_valid the next cycle.
- Pending on channel 1, a second e1dr toggle with sr = 38'h0_0000_0055 -> jdo unchanged, ovf_sticky = 1 (drop_cnt = 1 with STATS); ovf_clr -> ovf_sticky = 0.
- Accept and a new e1dr edge in the same cycle, with ir_q = 0 and sr = 38'h0_0000_0011 -> no overflow, cmd_valid = 4'b0001, cmd_act = 0, jdo = 38'h0_0000_0011.
- NUM_CMD = 3, ir_in = 2'd3, e1dr toggle -> single-cycle bad_ir, cmd_valid remains 0.
- Reset asserted while cmd_valid = 4'b0100 -> all outputs 0 in the next cycle; a subsequent toggle pair is decoded normally.
